mac_dot_engine: RTL and testbench

Parametrised, pipelined multiply-accumulate engine that computes the dot product of a programmable-length stream of operand pairs. It is the successor to the team's fixed 4-bit free-running MAC and adds:
- configurable widths;
- signed or unsigned arithmetic;
- optional saturation with a sticky overflow flag;
- a vector-length counter, input and output valid/ready handshakes, and a held result.

It sits between an operand-streaming front end and a result consumer in the datapath.

---
 rtl/mac_dot_engine.sv | 161 ++++++++++++++++
 tb/tb_mac_dot_engine.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_dot_engine.sv
// Pipelined dot-product MAC: streams len operand pairs through a 3-stage
// multiply/accumulate pipe with optional saturation and a sticky overflow flag.
module mac_dot_engine #(
   parameter int unsigned IN_W     = 8,
   parameter int unsigned ACC_W    = 24,
   parameter int unsigned LEN_W    = 8,
   parameter int unsigned SIGNED   = 1,
   parameter int unsigned SATURATE = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [LEN_W-1:0] len,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [IN_W-1:0]  a,
   input  logic [IN_W-1:0]  b,
   output logic             busy,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] result,
   output logic             overflow
);

   localparam int unsigned PROD_W = 2 * IN_W;
   localparam int unsigned SUM_W  = ACC_W + 1;
   localparam int unsigned PEXT_W = SUM_W - PROD_W;

   localparam logic [ACC_W-1:0] S_MAX = {1'b0, {(ACC_W-1){1'b1}}};
   localparam logic [ACC_W-1:0] S_MIN = {1'b1, {(ACC_W-1){1'b0}}};
   localparam logic [ACC_W-1:0] U_MAX = {ACC_W{1'b1}};

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   state_t             state;
   logic [LEN_W-1:0]   len_q;
   logic [LEN_W-1:0]   cnt;
   logic [ACC_W-1:0]   acc;
   logic               s1_v;
   logic [IN_W-1:0]    s1_a;
   logic [IN_W-1:0]    s1_b;
   logic               s2_v;
   logic [PROD_W-1:0]  s2_p;

   logic               fire;
   logic               last_beat;
   logic [PROD_W-1:0]  prod;
   logic               pext;
   logic               aext;
   logic [SUM_W-1:0]   sum;
   logic               ovf;
   logic [ACC_W-1:0]   acc_nxt;

   assign fire      = (state == RUN) && in_valid && in_ready;
   assign last_beat = (cnt == len_q - LEN_W'(1));
   assign result    = acc;

   // Operands are widened to the full product width so the multiply is exact.
   generate
      if (SIGNED != 0) begin : g_smul
         assign prod = $signed({{IN_W{s1_a[IN_W-1]}}, s1_a}) *
                       $signed({{IN_W{s1_b[IN_W-1]}}, s1_b});
      end else begin : g_umul
         assign prod = {{IN_W{1'b0}}, s1_a} * {{IN_W{1'b0}}, s1_b};
      end
   endgenerate

   // One extra bit of headroom exposes overflow; clamp or wrap as configured.
   always_comb begin
      pext    = (SIGNED != 0) ? s2_p[PROD_W-1] : 1'b0;
      aext    = (SIGNED != 0) ? acc[ACC_W-1]   : 1'b0;
      sum     = {aext, acc} + {{PEXT_W{pext}}, s2_p};
      ovf     = (SIGNED != 0) ? (sum[ACC_W] ^ sum[ACC_W-1]) : sum[ACC_W];
      acc_nxt = sum[ACC_W-1:0];
      if (ovf && (SATURATE != 0)) begin
         if (SIGNED != 0) begin
            acc_nxt = sum[ACC_W] ? S_MIN : S_MAX;
         end else begin
            acc_nxt = U_MAX;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         in_ready  <= 1'b0;
         busy      <= 1'b0;
         out_valid <= 1'b0;
         acc       <= '0;
         overflow  <= 1'b0;
         cnt       <= '0;
         len_q     <= '0;
         s1_v      <= 1'b0;
         s1_a      <= '0;
         s1_b      <= '0;
         s2_v      <= 1'b0;
         s2_p      <= '0;
      end else begin
         s1_v <= fire;
         if (fire) begin
            s1_a <= a;
            s1_b <= b;
         end
         s2_v <= s1_v;
         if (s1_v) begin
            s2_p <= prod;
         end
         if (s2_v) begin
            acc <= acc_nxt;
            if (ovf) begin
               overflow <= 1'b1;
            end
         end

         case (state)
            IDLE: begin
               if (start) begin
                  acc      <= '0;
                  overflow <= 1'b0;
                  cnt      <= '0;
                  busy     <= 1'b1;
                  if (len != '0) begin
                     len_q    <= len;
                     in_ready <= 1'b1;
                     state    <= RUN;
                  end else begin
                     out_valid <= 1'b1;
                     state     <= DONE;
                  end
               end
            end
            RUN: begin
               if (fire) begin
                  cnt <= cnt + LEN_W'(1);
                  if (last_beat) begin
                     in_ready <= 1'b0;
                     state    <= DRAIN;
                  end
               end
            end
            // Stage 1 empty means the last product is being accumulated now.
            DRAIN: begin
               if (!s1_v) begin
                  out_valid <= 1'b1;
                  state     <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  busy      <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mac_dot_engine.sv
// Directed bench for mac_dot_engine: four parameterisations share one stimulus
// stream; each step checks the instance whose configuration it targets.
module tb_mac_dot_engine;

   logic        clk;
   logic        rst;
   logic        start;
   logic [7:0]  len;
   logic        in_valid;
   logic [7:0]  a;
   logic [7:0]  b;
   logic        out_ready;

   logic        ir_s24, busy_s24, vld_s24, ov_s24;
   logic [23:0] r_s24;
   logic        ir_s16, busy_s16, vld_s16, ov_s16;
   logic [15:0] r_s16;
   logic        ir_w16, busy_w16, vld_w16, ov_w16;
   logic [15:0] r_w16;
   logic        ir_u24, busy_u24, vld_u24, ov_u24;
   logic [23:0] r_u24;

   int n_asserts;
   int n_fail;

   mac_dot_engine #(.IN_W(8), .ACC_W(24), .LEN_W(8), .SIGNED(1), .SATURATE(1)) u_s24 (
      .clk(clk), .rst(rst), .start(start), .len(len), .in_valid(in_valid), .in_ready(ir_s24),
      .a(a), .b(b), .busy(busy_s24), .out_valid(vld_s24), .out_ready(out_ready),
      .result(r_s24), .overflow(ov_s24));

   mac_dot_engine #(.IN_W(8), .ACC_W(16), .LEN_W(8), .SIGNED(1), .SATURATE(1)) u_s16 (
      .clk(clk), .rst(rst), .start(start), .len(len), .in_valid(in_valid), .in_ready(ir_s16),
      .a(a), .b(b), .busy(busy_s16), .out_valid(vld_s16), .out_ready(out_ready),
      .result(r_s16), .overflow(ov_s16));

   mac_dot_engine #(.IN_W(8), .ACC_W(16), .LEN_W(8), .SIGNED(1), .SATURATE(0)) u_w16 (
      .clk(clk), .rst(rst), .start(start), .len(len), .in_valid(in_valid), .in_ready(ir_w16),
      .a(a), .b(b), .busy(busy_w16), .out_valid(vld_w16), .out_ready(out_ready),
      .result(r_w16), .overflow(ov_w16));

   mac_dot_engine #(.IN_W(8), .ACC_W(24), .LEN_W(8), .SIGNED(0), .SATURATE(1)) u_u24 (
      .clk(clk), .rst(rst), .start(start), .len(len), .in_valid(in_valid), .in_ready(ir_u24),
      .a(a), .b(b), .busy(busy_u24), .out_valid(vld_u24), .out_ready(out_ready),
      .result(r_u24), .overflow(ov_u24));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      n_asserts++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic chkw(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_asserts++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic go(input logic [7:0] l);
      start = 1'b1;
      len   = l;
      step();
      start = 1'b0;
   endtask

   task automatic send(input logic [7:0] av, input logic [7:0] bv);
      a        = av;
      b        = bv;
      in_valid = 1'b1;
      step();
   endtask

   initial begin
      n_asserts = 0;
      n_fail    = 0;
      rst       = 1'b1;
      start     = 1'b0;
      len       = 8'd0;
      in_valid  = 1'b0;
      a         = 8'd0;
      b         = 8'd0;
      out_ready = 1'b0;
      step();
      step();

      // Reset state of every instance
      chk1("rst_s24_ir", ir_s24, 1'b0);   chk1("rst_s24_busy", busy_s24, 1'b0);
      chk1("rst_s24_vld", vld_s24, 1'b0); chk1("rst_s24_ov", ov_s24, 1'b0);
      chkw("rst_s24_res", 32'(r_s24), 32'd0);
      chk1("rst_s16_ir", ir_s16, 1'b0);   chk1("rst_s16_busy", busy_s16, 1'b0);
      chk1("rst_s16_vld", vld_s16, 1'b0); chk1("rst_s16_ov", ov_s16, 1'b0);
      chkw("rst_s16_res", 32'(r_s16), 32'd0);
      chk1("rst_w16_ir", ir_w16, 1'b0);   chk1("rst_w16_busy", busy_w16, 1'b0);
      chk1("rst_w16_vld", vld_w16, 1'b0); chk1("rst_w16_ov", ov_w16, 1'b0);
      chkw("rst_w16_res", 32'(r_w16), 32'd0);
      chk1("rst_u24_ir", ir_u24, 1'b0);   chk1("rst_u24_busy", busy_u24, 1'b0);
      chk1("rst_u24_vld", vld_u24, 1'b0); chk1("rst_u24_ov", ov_u24, 1'b0);
      chkw("rst_u24_res", 32'(r_u24), 32'd0);
      rst = 1'b0;

      // Signed dot product {3,-2,5}.{4,7,-1} = -7
      go(8'd3);
      chk1("t1_busy", busy_s24, 1'b1);
      chk1("t1_in_ready", ir_s24, 1'b1);
      send(8'd3, 8'd4);
      send(8'hFE, 8'd7);
      send(8'd5, 8'hFF);
      in_valid = 1'b0;
      chk1("t1_ready_drop", ir_s24, 1'b0);
      step();
      chk1("t1_vld_k1", vld_s24, 1'b0);
      step();
      chk1("t1_vld_k2", vld_s24, 1'b1);
      chkw("t1_result", 32'(r_s24), 32'h00FF_FFF9);
      chk1("t1_ov", ov_s24, 1'b0);
      out_ready = 1'b1;
      step();
      chk1("t1_vld_drop", vld_s24, 1'b0);
      chk1("t1_idle", busy_s24, 1'b0);
      out_ready = 1'b0;

      // Positive saturation: 4 x 127*127 = 64516
      go(8'd4);
      send(8'd127, 8'd127);
      send(8'd127, 8'd127);
      send(8'd127, 8'd127);
      send(8'd127, 8'd127);
      in_valid = 1'b0;
      step();
      step();
      chk1("t2_vld", vld_s16, 1'b1);
      chkw("t2_sat_res", 32'(r_s16), 32'h0000_7FFF);
      chk1("t2_sat_ov", ov_s16, 1'b1);
      chkw("t2_wrap_res", 32'(r_w16), 32'h0000_FC04);
      chk1("t2_wrap_ov", ov_w16, 1'b1);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;

      // Negative saturation: 3 x -128*127 = -48768
      go(8'd3);
      chk1("t3_ov_clr_sat", ov_s16, 1'b0);
      chk1("t3_ov_clr_wrap", ov_w16, 1'b0);
      send(8'h80, 8'd127);
      send(8'h80, 8'd127);
      send(8'h80, 8'd127);
      in_valid = 1'b0;
      step();
      step();
      chkw("t3_sat_res", 32'(r_s16), 32'h0000_8000);
      chk1("t3_sat_ov", ov_s16, 1'b1);
      chkw("t3_wrap_res", 32'(r_w16), 32'h0000_4180);
      chk1("t3_wrap_ov", ov_w16, 1'b1);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;

      // Bubbles, ignored start pulses and consumer backpressure: 1+4+9+16 = 30
      go(8'd4);
      send(8'd1, 8'd1);
      in_valid = 1'b0;
      start    = 1'b1;
      len      = 8'd0;
      step();
      start = 1'b0;
      chk1("t4_run_busy", busy_s24, 1'b1);
      chk1("t4_run_ready", ir_s24, 1'b1);
      chk1("t4_run_vld", vld_s24, 1'b0);
      send(8'd2, 8'd2);
      in_valid = 1'b0;
      step();
      send(8'd3, 8'd3);
      in_valid = 1'b0;
      step();
      send(8'd4, 8'd4);
      chk1("t4_ready_drop", ir_s24, 1'b0);
      in_valid = 1'b0;
      step();
      step();
      chk1("t4_vld", vld_s24, 1'b1);
      chkw("t4_result", 32'(r_s24), 32'd30);
      start    = 1'b1;
      len      = 8'd2;
      in_valid = 1'b1;
      a        = 8'd100;
      b        = 8'd100;
      for (int i = 0; i < 5; i++) begin
         step();
         chkw("t4_hold_res", 32'(r_s24), 32'd30);
         chk1("t4_hold_vld", vld_s24, 1'b1);
      end
      start     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      step();
      chk1("t4_vld_drop", vld_s24, 1'b0);
      chk1("t4_idle", busy_s24, 1'b0);
      out_ready = 1'b0;

      // Zero-length vector completes at the start edge
      go(8'd0);
      chk1("t5_zero_vld", vld_s24, 1'b1);
      chkw("t5_zero_res", 32'(r_s24), 32'd0);
      chk1("t5_zero_busy", busy_s24, 1'b1);
      chk1("t5_zero_ready", ir_s24, 1'b0);
      out_ready = 1'b1;
      step();
      chk1("t5_zero_done", vld_s24, 1'b0);

      // Unsigned 2 x 255*255 = 130050, out_ready already high
      go(8'd2);
      send(8'd255, 8'd255);
      send(8'd255, 8'd255);
      in_valid = 1'b0;
      step();
      step();
      chk1("t5_u_vld", vld_u24, 1'b1);
      chkw("t5_u_res", 32'(r_u24), 32'h0001_FC02);
      chk1("t5_u_ov", ov_u24, 1'b0);
      chkw("t5_s_res", 32'(r_s24), 32'd2);
      step();
      chk1("t5_u_handshake", vld_u24, 1'b0);
      out_ready = 1'b0;

      // Reset after 2 of 5 beats, then a fresh len=1 vector
      go(8'd5);
      send(8'd10, 8'd10);
      send(8'd10, 8'd10);
      in_valid = 1'b0;
      step();
      step();
      chkw("t6_partial", 32'(r_s24), 32'd200);
      in_valid = 1'b1;
      rst      = 1'b1;
      #2;
      chk1("t6_rst_ir", ir_s24, 1'b0);
      chk1("t6_rst_busy", busy_s24, 1'b0);
      chk1("t6_rst_vld", vld_s24, 1'b0);
      chk1("t6_rst_ov", ov_s24, 1'b0);
      chkw("t6_rst_res", 32'(r_s24), 32'd0);
      step();
      rst      = 1'b0;
      in_valid = 1'b0;
      go(8'd1);
      send(8'd2, 8'd3);
      in_valid = 1'b0;
      step();
      step();
      chk1("t6_vld", vld_s24, 1'b1);
      chkw("t6_result", 32'(r_s24), 32'd6);
      chk1("t6_ov", ov_s24, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end

endmodule
